// File: rtl/aes_inv_key_expansion_128.sv
// -----------------------------------------------------------------------------
// aes_inv_key_expansion_128
//
// Walks the AES-128 key schedule backwards. The round-10 key is loaded on
// start, and the round keys are then emitted in the order 10, 9, ..., 0, one
// per valid/ready handshake. Each earlier round key is derived from the
// current one, so the inverse cipher never needs an 11-entry key store.
//
// Ports
//   clk           in   1    rising-edge clock
//   reset         in   1    asynchronous, active-low reset
//   start         in   1    load last_key and begin (sampled in IDLE only)
//   last_key      in   128  round-10 key, word 0 in [127:96]
//   subkey        out  128  current round key, word 0 in [127:96]
//   subkey_round  out  4    round index of subkey (10 down to 0)
//   subkey_valid  out  1    subkey/subkey_round are valid
//   subkey_ready  in   1    consumer accepts subkey this cycle
//   busy          out  1    high from start acceptance until round-0 key accepted
//   done          out  1    one-cycle pulse after the round-0 key is accepted
//
// Also contains aes_sbox, the forward AES S-box used for SubWord.
// -----------------------------------------------------------------------------

module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Forward AES S-box, entry 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX[in_i];

endmodule


module aes_inv_key_expansion_128 #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] last_key,
    output logic [KEY_W-1:0] subkey,
    output logic [3:0]       subkey_round,
    output logic             subkey_valid,
    input  logic             subkey_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        FIN
    } state_e;

    state_e           state_q, state_d;
    logic [KEY_W-1:0] subkey_q, subkey_d;
    logic [3:0]       round_q, round_d;

    logic             handshake;
    logic [31:0]      w0, w1, w2, w3;
    logic [31:0]      p0, p1, p2, p3;
    logic [31:0]      rotP3, subRotP3;
    logic [7:0]       rconByte;
    logic [KEY_W-1:0] prevKey;

    assign handshake = subkey_valid && subkey_ready;

    // One backward step of the schedule. Words 1..3 of the earlier key are
    // recovered by XOR alone; word 0 needs the recovered word 3 passed through
    // RotWord/SubWord, exactly as the forward schedule built it.
    assign w0 = subkey_q[127:96];
    assign w1 = subkey_q[95:64];
    assign w2 = subkey_q[63:32];
    assign w3 = subkey_q[31:0];

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    assign rotP3 = {p3[23:0], p3[31:24]};

    aes_sbox sbox0 (.in_i(rotP3[31:24]), .out_o(subRotP3[31:24]));
    aes_sbox sbox1 (.in_i(rotP3[23:16]), .out_o(subRotP3[23:16]));
    aes_sbox sbox2 (.in_i(rotP3[15:8]),  .out_o(subRotP3[15:8]));
    aes_sbox sbox3 (.in_i(rotP3[7:0]),   .out_o(subRotP3[7:0]));

    // Rcon for the round being stepped away from. Round 0 never steps, so
    // its entry is never consumed.
    always_comb begin
        rconByte = 8'h00;
        case (round_q)
            4'd1:    rconByte = 8'h01;
            4'd2:    rconByte = 8'h02;
            4'd3:    rconByte = 8'h04;
            4'd4:    rconByte = 8'h08;
            4'd5:    rconByte = 8'h10;
            4'd6:    rconByte = 8'h20;
            4'd7:    rconByte = 8'h40;
            4'd8:    rconByte = 8'h80;
            4'd9:    rconByte = 8'h1b;
            4'd10:   rconByte = 8'h36;
            default: rconByte = 8'h00;
        endcase
    end

    assign p0      = w0 ^ subRotP3 ^ {rconByte, 24'h000000};
    assign prevKey = {p0, p1, p2, p3};

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            subkey_q <= '0;
            round_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            subkey_q <= subkey_d;
            round_q  <= round_d;
        end
    end

    // Next state and next key. Keys hold whenever there is no handshake;
    // after the round-0 handshake the register keeps K(0).
    always_comb begin
        state_d  = state_q;
        subkey_d = subkey_q;
        round_d  = round_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = EMIT;
                    subkey_d = last_key;
                    round_d  = 4'(NUM_ROUNDS);
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (round_q == 4'd0) begin
                        state_d = FIN;
                    end else begin
                        subkey_d = prevKey;
                        round_d  = round_q - 4'd1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the state.
    always_comb begin
        subkey_valid = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            EMIT: begin
                subkey_valid = 1'b1;
                busy         = 1'b1;
            end
            FIN: begin
                done = 1'b1;
            end
            default: begin
                subkey_valid = 1'b0;
            end
        endcase
    end

    assign subkey       = subkey_q;
    assign subkey_round = round_q;

endmodule

// File: tb/tb_aes_inv_key_expansion_128.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_key_expansion_128
//
// Self-checking bench for aes_inv_key_expansion_128. A forward AES-128 key
// schedule (S-box computed from GF(2^8) inversion plus the affine map) gives
// the expected round keys; the DUT must reproduce them in reverse order.
// -----------------------------------------------------------------------------

module tb_aes_inv_key_expansion_128;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] last_key;
    logic [127:0] subkey;
    logic [3:0]   subkey_round;
    logic         subkey_valid;
    logic         subkey_ready;
    logic         busy;
    logic         done;

    int           vectorCount;
    int           missCount;
    logic [127:0] refKeys [0:10];
    logic [127:0] seen    [0:10];

    aes_inv_key_expansion_128 dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .last_key     (last_key),
        .subkey       (subkey),
        .subkey_round (subkey_round),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls outside the bounded loops.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // GF(2^8) multiply with the AES polynomial.
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d = {x, x};
        return d[15-n -: 8];
    endfunction

    // S-box: multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sboxRef(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gfMul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWordRef(input logic [31:0] w);
        return {sboxRef(w[31:24]), sboxRef(w[23:16]), sboxRef(w[15:8]), sboxRef(w[7:0])};
    endfunction

    // Forward AES-128 key expansion into refKeys[0..10].
    task automatic buildSchedule(input logic [127:0] cipherKey);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = cipherKey[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subWordRef({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gfMul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) refKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] junkKey();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Called at a negedge in IDLE; leaves us at the negedge after acceptance.
    task automatic applyStimulus(input logic [127:0] key);
        start    = 1'b1;
        last_key = key;
        @(negedge clk);
        start    = 1'b0;
        last_key = junkKey();
    endtask

    // Consumes one full sequence against refKeys with random readiness,
    // optionally hammering start with foreign keys. Ends at the FIN negedge.
    task automatic runSequence(input int readyPct, input bit pokeStart);
        int expRound = 10;
        int cycles   = 0;
        bit finished = 1'b0;
        bit rdy;
        while (!finished && cycles < 300) begin
            checkOutput("seq_valid", 128'(subkey_valid), 128'd1);
            checkOutput("seq_round", 128'(subkey_round), 128'(expRound));
            checkOutput("seq_key",   subkey, refKeys[expRound]);
            checkOutput("seq_busy",  128'(busy), 128'd1);
            checkOutput("seq_done",  128'(done), 128'd0);
            rdy          = (int'($urandom_range(99)) < readyPct);
            subkey_ready = rdy;
            if (pokeStart) begin
                start    = 1'($urandom_range(1));
                last_key = junkKey();
            end
            @(negedge clk);
            cycles++;
            if (rdy) begin
                if (expRound == 0) finished = 1'b1;
                else expRound--;
            end
        end
        start = 1'b0;
        checkOutput("seq_completed", 128'(finished), 128'd1);
        checkOutput("fin_done",  128'(done), 128'd1);
        checkOutput("fin_valid", 128'(subkey_valid), 128'd0);
        checkOutput("fin_busy",  128'(busy), 128'd0);
        checkOutput("fin_key",   subkey, refKeys[0]);
    endtask

    // From the FIN negedge: assert start with a junk key (must be ignored),
    // step to IDLE and confirm nothing started.
    task automatic finToIdle(input bit holdStart);
        start    = 1'b1;
        last_key = junkKey();
        @(negedge clk);
        checkOutput("idle_valid", 128'(subkey_valid), 128'd0);
        checkOutput("idle_busy",  128'(busy), 128'd0);
        checkOutput("idle_done",  128'(done), 128'd0);
        if (!holdStart) start = 1'b0;
    endtask

    initial begin
        int guard;
        vectorCount  = 0;
        missCount    = 0;
        reset        = 1'b0;
        start        = 1'b0;
        last_key     = '0;
        subkey_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_subkey", subkey, 128'd0);
        checkOutput("rst_round",  128'(subkey_round), 128'd0);
        checkOutput("rst_valid",  128'(subkey_valid), 128'd0);
        checkOutput("rst_busy",   128'(busy), 128'd0);
        checkOutput("rst_done",   128'(done), 128'd0);
        reset = 1'b1;
        @(negedge clk);

        // FIPS-197 A.1 with ready tied high.
        $display("[TB] FIPS-197 vector, full rate");
        buildSchedule(128'h2b7e151628aed2a6abf7158809cf4f3c);
        subkey_ready = 1'b1;
        applyStimulus(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int i = 0; i <= 10; i++) begin
            seen[i] = subkey;
            checkOutput("fips_valid", 128'(subkey_valid), 128'd1);
            @(negedge clk);
        end
        checkOutput("fips_done_12th", 128'(done), 128'd1);
        checkOutput("fips_round10", seen[0],  128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        checkOutput("fips_round9",  seen[1],  128'hac7766f319fadc2128d12941575c006e);
        checkOutput("fips_round0",  seen[10], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        for (int i = 0; i <= 10; i++) checkOutput("fips_model_key", seen[i], refKeys[10-i]);
        @(negedge clk);
        checkOutput("fips_done_drop", 128'(done), 128'd0);

        // Same key under random backpressure.
        $display("[TB] FIPS-197 vector, random backpressure");
        applyStimulus(refKeys[10]);
        runSequence(50, 1'b0);
        @(negedge clk);

        // start while busy and in FIN must be ignored.
        $display("[TB] start ignored while busy and in FIN");
        buildSchedule(junkKey());
        applyStimulus(refKeys[10]);
        runSequence(60, 1'b1);
        finToIdle(1'b0);

        // Back-to-back sequences, start held from FIN into IDLE.
        $display("[TB] back-to-back sequences");
        buildSchedule(junkKey());
        subkey_ready = 1'b1;
        applyStimulus(refKeys[10]);
        runSequence(100, 1'b0);
        buildSchedule(junkKey());
        finToIdle(1'b1);
        last_key = refKeys[10];
        @(negedge clk);
        start    = 1'b0;
        last_key = junkKey();
        runSequence(100, 1'b0);
        @(negedge clk);

        // Reset in the middle of a sequence.
        $display("[TB] asynchronous reset mid-sequence");
        buildSchedule(junkKey());
        subkey_ready = 1'b1;
        applyStimulus(refKeys[10]);
        guard = 0;
        while (subkey_round !== 4'd5 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("mid_reached_round5", 128'(subkey_round), 128'd5);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_subkey", subkey, 128'd0);
        checkOutput("mid_rst_round",  128'(subkey_round), 128'd0);
        checkOutput("mid_rst_valid",  128'(subkey_valid), 128'd0);
        checkOutput("mid_rst_busy",   128'(busy), 128'd0);
        checkOutput("mid_rst_done",   128'(done), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_valid", 128'(subkey_valid), 128'd0);
        buildSchedule(junkKey());
        applyStimulus(refKeys[10]);
        runSequence(100, 1'b0);
        @(negedge clk);

        // Round trip of random cipher keys.
        $display("[TB] random cipher keys round trip");
        for (int k = 0; k < 100; k++) begin
            buildSchedule(junkKey());
            applyStimulus(refKeys[10]);
            runSequence((k % 2 == 0) ? 50 : 100, 1'b0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
